// File: rtl/tx_word_sequencer_1553.sv
// Transmit word sequencer for encoder_1553: descriptor FIFO, single-cycle
// csw/dw launch strobes, tx_busy handshake with timeout and inter-word gap.
module tx_word_sequencer_1553 #(
  parameter int DEPTH        = 16,
  parameter int GAP_CYCLES   = 8,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                     enc_clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     wr_en,
  input  logic [17:0]              wr_word,
  input  logic                     tx_busy,
  output logic [15:0]              tx_dword,
  output logic                     tx_csw,
  output logic                     tx_dw,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     err_sync,
  output logic                     err_timeout,
  output logic [15:0]              words_sent
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_BUSY,
    S_GAP
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic [17:0]     r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic [17:0]     r_hold;
  logic [15:0]     r_dword;
  logic [15:0]     r_sent;
  logic            r_overflow;
  logic [TW-1:0]   r_timer;
  logic [GW-1:0]   r_gap;

  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic            w_push;
  logic            w_launch;
  logic            w_err_sync;
  logic            w_err_tmo;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = (r_state == S_IDLE) && enable && !w_empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign w_push  = wr_en && (!w_full || w_pop);

  always_ff @(posedge enc_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= wr_word;
    end
  end

  always_ff @(posedge enc_clk or posedge rst) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_hold     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= wr_en && !w_push;
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
        r_hold <= r_mem[r_rptr];
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    w_launch   = 1'b0;
    w_err_sync = 1'b0;
    w_err_tmo  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_pop) begin
          w_next = S_POP;
        end
      end
      S_POP: begin
        if (r_hold[17] ^ r_hold[16]) begin
          w_launch = 1'b1;
          w_next   = S_LAUNCH;
        end else begin
          w_err_sync = 1'b1;
          w_next     = S_IDLE;
        end
      end
      S_LAUNCH: begin
        w_next = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          w_next = S_BUSY;
        end else if (r_timer == TW'(BUSY_TIMEOUT - 1)) begin
          w_err_tmo = 1'b1;
          w_next    = S_GAP;
        end
      end
      S_BUSY: begin
        if (!tx_busy) begin
          w_next = S_GAP;
        end
      end
      S_GAP: begin
        // Busy reappearing during the gap is treated as a still-running word.
        if (tx_busy) begin
          w_next = S_BUSY;
        end else if (r_gap == GW'(GAP_CYCLES - 1)) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge enc_clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_dword <= '0;
      r_sent  <= '0;
      r_timer <= '0;
      r_gap   <= '0;
    end else begin
      r_state <= w_next;
      if (w_launch) begin
        r_dword <= r_hold[15:0];
        r_sent  <= r_sent + 16'd1;
      end
      if (r_state == S_WAIT_BUSY) begin
        r_timer <= r_timer + TW'(1);
      end else begin
        r_timer <= '0;
      end
      if (r_state == S_GAP) begin
        r_gap <= r_gap + GW'(1);
      end else begin
        r_gap <= '0;
      end
    end
  end

  assign tx_dword    = r_dword;
  assign tx_csw      = (r_state == S_LAUNCH) && r_hold[17];
  assign tx_dw       = (r_state == S_LAUNCH) && r_hold[16];
  assign full        = w_full;
  assign empty       = w_empty;
  assign count       = r_count;
  assign overflow    = r_overflow;
  assign err_sync    = w_err_sync;
  assign err_timeout = w_err_tmo;
  assign words_sent  = r_sent;

endmodule

// File: tb/tb_tx_word_sequencer_1553.sv
// Bench for tx_word_sequencer_1553: vector table, expected-strobe scoreboard,
// encoder busy model and hand-written reset / overflow / timeout sequences.
module tb_tx_word_sequencer_1553;

  localparam int DEPTH = 16;
  localparam int G     = 8;
  localparam int BT    = 4;

  logic        enc_clk = 1'b0;
  logic        rst     = 1'b1;
  logic        enable  = 1'b0;
  logic        wr_en   = 1'b0;
  logic [17:0] wr_word = '0;
  logic        tx_busy = 1'b0;
  logic [15:0] tx_dword;
  logic        tx_csw;
  logic        tx_dw;
  logic        full;
  logic        empty;
  logic [4:0]  count;
  logic        overflow;
  logic        err_sync;
  logic        err_timeout;
  logic [15:0] words_sent;

  tx_word_sequencer_1553 #(
    .DEPTH(DEPTH),
    .GAP_CYCLES(G),
    .BUSY_TIMEOUT(BT)
  ) dut (
    .enc_clk(enc_clk),
    .rst(rst),
    .enable(enable),
    .wr_en(wr_en),
    .wr_word(wr_word),
    .tx_busy(tx_busy),
    .tx_dword(tx_dword),
    .tx_csw(tx_csw),
    .tx_dw(tx_dw),
    .full(full),
    .empty(empty),
    .count(count),
    .overflow(overflow),
    .err_sync(err_sync),
    .err_timeout(err_timeout),
    .words_sent(words_sent)
  );

  always #5 enc_clk = ~enc_clk;

  typedef struct {
    logic [17:0] word;
    logic        ecsw;
    logic        edw;
    logic        esync;
    logic [15:0] edword;
  } vec_t;

  typedef struct {
    logic        csw;
    logic        dw;
    logic        err;
    logic [15:0] dword;
  } exp_t;

  vec_t vt [6];
  exp_t q [$];

  int cyc, n_vec, n_bad;
  int n_strobe, n_sync, n_tmo, n_ovf;
  int busy_len, bh, last_kind;
  int last_strobe, fall_cyc, tmo_cyc, ovf_cyc, wr_cyc;
  bit lat_arm;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic fail_evt(input string nm);
    n_vec++;
    n_bad++;
    $display("FAIL %s: seen 1 allowed 0", nm);
  endtask

  task automatic push_exp(input logic c, input logic d, input logic e,
                          input logic [15:0] w);
    exp_t x;
    x.csw   = c;
    x.dw    = d;
    x.err   = e;
    x.dword = w;
    q.push_back(x);
  endtask

  task automatic mon();
    exp_t e;
    if (rst) begin
      tx_busy = 1'b0;
      bh      = 0;
      return;
    end
    if (tx_csw || tx_dw) begin
      n_strobe++;
      if (q.size() == 0) begin
        fail_evt("unexpected_strobe");
      end else begin
        e = q.pop_front();
        chk("strobe_not_err", e.err, 0);
        chk("strobe_csw", tx_csw, e.csw);
        chk("strobe_dw", tx_dw, e.dw);
        chk("tx_dword", tx_dword, e.dword);
      end
      if (lat_arm) begin
        chk("launch_latency", cyc - wr_cyc, 3);
        lat_arm = 1'b0;
      end
      if (last_kind == 1) begin
        chk("gap_after_busy", cyc - fall_cyc, G + 3);
      end else if (last_kind == 2) begin
        chk("gap_after_timeout", cyc - tmo_cyc, G + 3);
      end
      last_kind   = 0;
      last_strobe = cyc;
      if (busy_len > 0) begin
        tx_busy = 1'b1;
        bh      = busy_len;
      end
    end else if (bh > 0) begin
      bh--;
      if (bh == 0) begin
        tx_busy   = 1'b0;
        fall_cyc  = cyc;
        last_kind = 1;
      end
    end
    if (err_timeout) begin
      n_tmo++;
      chk("timeout_latency", cyc - last_strobe, BT);
      tmo_cyc   = cyc;
      last_kind = 2;
    end
    if (err_sync) begin
      n_sync++;
      if (q.size() == 0) begin
        fail_evt("unexpected_err_sync");
      end else begin
        e = q.pop_front();
        chk("err_sync_expected", e.err, 1);
      end
    end
    if (overflow) begin
      n_ovf++;
      ovf_cyc = cyc;
    end
  endtask

  task automatic tick();
    @(negedge enc_clk);
    cyc++;
    mon();
  endtask

  task automatic settle(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_strobes(input int target, input int budget,
                              input string nm);
    int k;
    k = 0;
    while (n_strobe < target && k < budget) begin
      tick();
      k++;
    end
    chk(nm, n_strobe, target);
  endtask

  task automatic write1(input logic [17:0] w);
    wr_en   = 1'b1;
    wr_word = w;
    wr_cyc  = cyc;
    push_exp(w[17], w[16], !(w[17] ^ w[16]), w[15:0]);
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    int base, ws0, s0, t0, o0;
    logic [17:0] w;
    bit b;

    vt[0] = '{18'h2ABCD, 1'b1, 1'b0, 1'b0, 16'hABCD};
    vt[1] = '{18'h1FFFF, 1'b0, 1'b1, 1'b0, 16'hFFFF};
    vt[2] = '{18'h11234, 1'b0, 1'b1, 1'b0, 16'h1234};
    vt[3] = '{18'h25678, 1'b1, 1'b0, 1'b0, 16'h5678};
    vt[4] = '{18'h01111, 1'b0, 1'b0, 1'b1, 16'h1111};
    vt[5] = '{18'h32222, 1'b0, 1'b0, 1'b1, 16'h2222};

    cyc = 0; n_vec = 0; n_bad = 0;
    n_strobe = 0; n_sync = 0; n_tmo = 0; n_ovf = 0;
    busy_len = 0; bh = 0; last_kind = 0; lat_arm = 1'b0;
    last_strobe = 0; fall_cyc = 0; tmo_cyc = 0; ovf_cyc = 0; wr_cyc = 0;

    settle(3);
    chk("rst_tx_csw", tx_csw, 0);
    chk("rst_tx_dw", tx_dw, 0);
    chk("rst_tx_dword", tx_dword, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_words_sent", words_sent, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_err_sync", err_sync, 0);
    chk("rst_err_timeout", err_timeout, 0);
    rst = 1'b0;
    tick();

    // single word, long busy, then a second word queued behind it
    enable   = 1'b1;
    busy_len = 40;
    lat_arm  = 1'b1;
    write1(18'h25555);
    wait_strobes(1, 20, "t1_first_strobe");
    chk("t1_words_sent", words_sent, 1);
    chk("t1_dword", tx_dword, 16'h5555);
    write1(18'h1A5A5);
    wait_strobes(2, 80, "t1_second_strobe");
    chk("t1_words_sent2", words_sent, 2);
    settle(60);

    // table-driven back-to-back words
    busy_len  = 6;
    last_kind = 0;
    base      = n_strobe;
    for (int i = 0; i < 4; i++) begin
      wr_en   = 1'b1;
      wr_word = vt[i].word;
      push_exp(vt[i].ecsw, vt[i].edw, vt[i].esync, vt[i].edword);
      tick();
    end
    wr_en = 1'b0;
    wait_strobes(base + 4, 200, "t2_strobes");
    settle(30);
    chk("t2_words_sent", words_sent, 6);
    chk("t2_empty", empty, 1);
    chk("t2_last_dword", tx_dword, 16'h5678);

    // fill past DEPTH with launches disabled
    enable = 1'b0;
    base   = n_strobe;
    ws0    = words_sent;
    o0     = n_ovf;
    for (int i = 0; i <= DEPTH; i++) begin
      b       = (i % 2) == 1;
      w       = {b, ~b, 16'(256 + i)};
      wr_en   = 1'b1;
      wr_word = w;
      wr_cyc  = cyc;
      if (i < DEPTH) push_exp(b, ~b, 1'b0, w[15:0]);
      tick();
    end
    wr_en = 1'b0;
    tick();
    chk("t3_full", full, 1);
    chk("t3_count", count, DEPTH);
    chk("t3_overflow_pulses", n_ovf - o0, 1);
    chk("t3_overflow_cycle", ovf_cyc - wr_cyc, 1);
    chk("t3_held_idle", n_strobe, base);
    enable    = 1'b1;
    last_kind = 0;
    wait_strobes(base + DEPTH, DEPTH * 30 + 50, "t3_drain");
    settle(40);
    chk("t3_words_sent", words_sent - ws0, DEPTH);
    chk("t3_no_extra", n_strobe - base, DEPTH);
    chk("t3_empty", empty, 1);
    chk("t3_sb_drained", q.size(), 0);

    // malformed descriptors from the table
    base = n_strobe;
    ws0  = words_sent;
    s0   = n_sync;
    for (int i = 4; i < 6; i++) begin
      wr_en   = 1'b1;
      wr_word = vt[i].word;
      push_exp(vt[i].ecsw, vt[i].edw, vt[i].esync, vt[i].edword);
      tick();
    end
    wr_en = 1'b0;
    settle(20);
    chk("t4_sync_pulses", n_sync - s0, 2);
    chk("t4_words_sent", words_sent, ws0);
    chk("t4_no_strobe", n_strobe, base);
    chk("t4_empty", empty, 1);

    // encoder never answers
    busy_len  = 0;
    last_kind = 0;
    base      = n_strobe;
    t0        = n_tmo;
    write1(18'h20BAD);
    write1(18'h10C0D);
    wait_strobes(base + 2, 80, "t5_strobes");
    settle(20);
    chk("t5_timeouts", n_tmo - t0, 2);

    // reset while busy with words queued
    busy_len  = 30;
    last_kind = 0;
    base      = n_strobe;
    for (int i = 0; i < 4; i++) begin
      wr_en   = 1'b1;
      wr_word = vt[i].word;
      push_exp(vt[i].ecsw, vt[i].edw, vt[i].esync, vt[i].edword);
      tick();
    end
    wr_en = 1'b0;
    wait_strobes(base + 1, 20, "t6_first_strobe");
    settle(5);
    rst = 1'b1;
    #1;
    chk("t6_tx_csw", tx_csw, 0);
    chk("t6_tx_dw", tx_dw, 0);
    chk("t6_tx_dword", tx_dword, 0);
    chk("t6_count", count, 0);
    chk("t6_empty", empty, 1);
    chk("t6_full", full, 0);
    chk("t6_words_sent", words_sent, 0);
    chk("t6_overflow", overflow, 0);
    chk("t6_err_sync", err_sync, 0);
    chk("t6_err_timeout", err_timeout, 0);
    q.delete();
    settle(2);
    rst = 1'b0;
    settle(40);
    chk("t6_nothing_after", n_strobe, base + 1);
    chk("t6_still_empty", empty, 1);
    lat_arm = 1'b1;
    write1(18'h10F0F);
    wait_strobes(base + 2, 20, "t6_new_strobe");
    chk("t6_words_sent_new", words_sent, 1);
    settle(30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
